// File: rtl/mips_datapath_p_if.sv
// Control, memory and status bundle between the multicycle controller and mips_datapath_p.
// The controller side drives every control strobe and the memory read data.
interface mips_datapath_p_if #(
    parameter int WIDTH = 32
);
    logic             IorD;
    logic             IRWrite;
    logic             RegDest;
    logic             MemtoReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUControl;
    logic             Branch;
    logic             BranchNe;
    logic             PCWrite;
    logic [1:0]       PCSrc;
    logic [WIDTH-1:0] RD;
    logic [WIDTH-1:0] Adr;
    logic [WIDTH-1:0] WD;
    logic             overflow;
    logic             exc;
    logic [WIDTH-1:0] EPC;

    modport master (
        output IorD, IRWrite, RegDest, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
               ALUControl, Branch, BranchNe, PCWrite, PCSrc, RD,
        input  Adr, WD, overflow, exc, EPC
    );

    modport slave (
        input  IorD, IRWrite, RegDest, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
               ALUControl, Branch, BranchNe, PCWrite, PCSrc, RD,
        output Adr, WD, overflow, exc, EPC
    );
endinterface

// File: rtl/mips_datapath_p.sv
// Parametrised multicycle MIPS datapath; Adr/WD/overflow are combinational, all state updates on ck.
// Define DATAPATH_EXC_EN to capture overflow exceptions (exc/EPC) and suppress the faulting write-back.
module mips_datapath_p #(
    parameter int               WIDTH    = 32,
    parameter int               NREG     = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic              ck,
    input logic              reset_,
    mips_datapath_p_if.slave dp
);
    localparam int RW = $clog2(NREG);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      ir_q;
    logic [WIDTH-1:0] data_q, a_q, b_q, aluout_q;
    logic [WIDTH-1:0] rf_q [NREG];

    logic [RW-1:0]    rs, rt, rd, wa;
    logic [WIDTH-1:0] sign_imm, jump_tgt, src_a, src_b, alu_res, wd3;
    logic             alu_ovf, zero, pc_en, rf_we;

    assign rs       = ir_q[21 +: RW];
    assign rt       = ir_q[16 +: RW];
    assign rd       = ir_q[11 +: RW];
    assign wa       = dp.RegDest ? rd : rt;
    assign wd3      = dp.MemtoReg ? data_q : aluout_q;
    assign sign_imm = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
    assign jump_tgt = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
    assign src_a    = dp.ALUSrcA ? a_q : pc_q;

    always_comb begin
        src_b = b_q;
        case (dp.ALUSrcB)
            2'b00:   src_b = b_q;
            2'b01:   src_b = WIDTH'(4);
            2'b10:   src_b = sign_imm;
            default: src_b = {sign_imm[WIDTH-3:0], 2'b00};
        endcase
    end

    // Overflow is judged on the sign bits of the wrapped WIDTH-bit result.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (dp.ALUControl)
            3'b010: begin
                alu_res = src_a + src_b;
                alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            3'b110: begin
                alu_res = src_a - src_b;
                alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            3'b000:  alu_res = src_a & src_b;
            3'b001:  alu_res = src_a | src_b;
            3'b111:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_res = '0;
        endcase
    end

    assign zero  = (alu_res == '0);
    assign pc_en = dp.PCWrite | (dp.Branch & (zero ^ dp.BranchNe));

    always_comb begin
        pc_d = pc_q;
        case (dp.PCSrc)
            2'b00:   pc_d = alu_res;
            2'b01:   pc_d = aluout_q;
            2'b10:   pc_d = jump_tgt;
            default: pc_d = pc_q;
        endcase
    end

    assign dp.Adr      = dp.IorD ? aluout_q : pc_q;
    assign dp.WD       = b_q;
    assign dp.overflow = alu_ovf;

    always_ff @(posedge ck or negedge reset_) begin
        if (!reset_) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            data_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            if (pc_en) pc_q <= pc_d;
            if (dp.IRWrite) ir_q <= dp.RD[31:0];
            data_q   <= dp.RD;
            a_q      <= rf_q[rs];
            b_q      <= rf_q[rt];
            aluout_q <= alu_res;
        end
    end

    // Entry 0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge ck or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (rf_we && (wa != '0)) begin
            rf_q[wa] <= wd3;
        end
    end

`ifdef DATAPATH_EXC_EN
    logic             exc_q, ovf_q;
    logic [WIDTH-1:0] epc_q;

    // ovf_q marks that ALUOut now holds a faulting result.
    always_ff @(posedge ck or negedge reset_) begin
        if (!reset_) begin
            exc_q <= 1'b0;
            ovf_q <= 1'b0;
            epc_q <= '0;
        end else begin
            ovf_q <= alu_ovf;
            if (alu_ovf && !exc_q) begin
                exc_q <= 1'b1;
                epc_q <= pc_q - WIDTH'(4);
            end
        end
    end

    assign rf_we  = dp.RegWrite & ~(ovf_q & ~dp.MemtoReg);
    assign dp.exc = exc_q;
    assign dp.EPC = epc_q;
`else
    assign rf_we  = dp.RegWrite;
    assign dp.exc = 1'b0;
    assign dp.EPC = '0;
`endif

endmodule
